// File: rtl/csr_op_unit.sv
// Zicsr sequencer between execute and the CSR file: reads the CSR, conditionally
// writes the modified value, and returns the old value for rd or flags a fault.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// READ  | csr_read high, old value captured at the edge, access checks evaluated
// WRITE | csr_write high (unless killed) with the computed write data
// DONE  | one-cycle completion pulse carrying result and rd write-back
// FAULT | one-cycle illegal-instruction pulse; no write was issued
module csr_op_unit #(
  parameter int XLEN = 64
) (
  input  logic            phi2,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_num,
  input  logic [4:0]      src_idx,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [4:0]      rd_idx,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] result,
  output logic            illegal,
  output logic [11:0]     csr_addr,
  output logic            csr_read,
  output logic            csr_write,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_invalid
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Only the op kind (RW/RS/RC) is kept; funct3[2] is consumed when the operand is picked.
  logic [1:0]      op_q;
  logic [11:0]     csr_q;
  logic [4:0]      src_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] old_q;

  logic            accept;
  logic            do_write;
  logic [XLEN-1:0] wdata_calc;

  assign accept = (state == IDLE) && start && !kill;

  // Set/clear forms with a zero source index are pure reads, whatever rs1 holds.
  assign do_write = (op_q == 2'b01) || (src_q != 5'd0);

  always_comb begin
    case (op_q)
      2'b10:   wdata_calc = old_q | opnd_q;
      2'b11:   wdata_calc = old_q & ~opnd_q;
      default: wdata_calc = opnd_q;
    endcase
  end

  always_ff @(posedge phi2 or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op_q   <= 2'b00;
      csr_q  <= 12'd0;
      src_q  <= 5'd0;
      rd_q   <= 5'd0;
      opnd_q <= '0;
      old_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= funct3[1:0];
        csr_q  <= csr_num;
        src_q  <= src_idx;
        rd_q   <= rd_idx;
        opnd_q <= funct3[2] ? {{(XLEN-5){1'b0}}, src_idx} : rs1_val;
      end
      if (state == READ) begin
        old_q <= csr_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    illegal   = 1'b0;
    rd_we     = 1'b0;
    rd_addr   = 5'd0;
    result    = '0;
    csr_addr  = 12'd0;
    csr_read  = 1'b0;
    csr_write = 1'b0;
    csr_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (funct3[1:0] == 2'b00) ? FAULT : READ;
        end
      end
      READ: begin
        csr_read = 1'b1;
        csr_addr = csr_q;
        if (kill) begin
          state_nxt = IDLE;
        end else if (csr_invalid || (do_write && (csr_q[11:10] == 2'b11))) begin
          state_nxt = FAULT;
        end else begin
          state_nxt = do_write ? WRITE : DONE;
        end
      end
      WRITE: begin
        csr_addr  = csr_q;
        csr_wdata = wdata_calc;
        // kill gates the strobe combinationally so a flushed op never commits.
        csr_write = !kill;
        state_nxt = kill ? IDLE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        result    = old_q;
        rd_addr   = rd_q;
        rd_we     = (rd_q != 5'd0);
        state_nxt = IDLE;
      end
      FAULT: begin
        illegal   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_op_unit.sv
// Directed bench for csr_op_unit: a vector table of CSR ops with hand-computed
// strobes, write data and latency, plus kill and reset sequences.
module tb_csr_op_unit;

  localparam int XLEN = 64;

  logic            phi2;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [11:0]     csr_num;
  logic [4:0]      src_idx;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rd_idx;
  logic            kill;
  logic            busy;
  logic            done;
  logic            rd_we;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic [11:0]     csr_addr;
  logic            csr_read;
  logic            csr_write;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_invalid;

  int tests_run = 0;
  int tests_failed = 0;

  csr_op_unit #(.XLEN(XLEN)) dut (
    .phi2(phi2), .rst(rst), .start(start), .funct3(funct3), .csr_num(csr_num),
    .src_idx(src_idx), .rs1_val(rs1_val), .rd_idx(rd_idx), .kill(kill),
    .busy(busy), .done(done), .rd_we(rd_we), .rd_addr(rd_addr), .result(result),
    .illegal(illegal), .csr_addr(csr_addr), .csr_read(csr_read),
    .csr_write(csr_write), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_invalid(csr_invalid)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  typedef struct {
    logic [2:0]      f3;
    logic [11:0]     num;
    logic [4:0]      src;
    logic [XLEN-1:0] rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] old;
    logic            inv;
    logic            exp_rd;
    logic            exp_wr;
    logic [XLEN-1:0] exp_wdata;
    logic            exp_ill;
    int              exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic            rd_seen, wr_seen, addr_bad;
    logic [XLEN-1:0] wd, res;
    logic            rwe;
    logic [4:0]      radr;
    int              done_cyc, ill_cyc, pulses;
    rd_seen = 0; wr_seen = 0; addr_bad = 0; wd = '0; res = '0; rwe = 0; radr = '0;
    done_cyc = 0; ill_cyc = 0; pulses = 0;
    @(negedge phi2);
    funct3 = v.f3; csr_num = v.num; src_idx = v.src; rs1_val = v.rs1; rd_idx = v.rd;
    csr_rdata = v.old; csr_invalid = v.inv; start = 1'b1;
    @(posedge phi2);
    #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge phi2);
      if (csr_read) begin
        rd_seen = 1;
        if (csr_addr != v.num) addr_bad = 1;
      end
      if (csr_write) begin
        wr_seen = 1;
        wd = csr_wdata;
        if (csr_addr != v.num) addr_bad = 1;
      end
      if (done || illegal) pulses++;
      if (done && done_cyc == 0) begin
        done_cyc = k; res = result; rwe = rd_we; radr = rd_addr;
      end
      if (illegal && ill_cyc == 0) ill_cyc = k;
    end
    check($sformatf("v%0d_read_strobe", idx), {63'd0, rd_seen}, {63'd0, v.exp_rd});
    check($sformatf("v%0d_write_strobe", idx), {63'd0, wr_seen}, {63'd0, v.exp_wr});
    check($sformatf("v%0d_csr_addr", idx), {63'd0, addr_bad}, 64'd0);
    check($sformatf("v%0d_pulse_count", idx), 64'(pulses), 64'd1);
    if (v.exp_wr) check($sformatf("v%0d_wdata", idx), wd, v.exp_wdata);
    if (v.exp_ill) begin
      check($sformatf("v%0d_illegal_cycle", idx), 64'(ill_cyc), 64'(v.exp_lat));
      check($sformatf("v%0d_no_done", idx), 64'(done_cyc), 64'd0);
    end else begin
      check($sformatf("v%0d_done_cycle", idx), 64'(done_cyc), 64'(v.exp_lat));
      check($sformatf("v%0d_no_illegal", idx), 64'(ill_cyc), 64'd0);
      check($sformatf("v%0d_result", idx), res, v.old);
      check($sformatf("v%0d_rd_we", idx), {63'd0, rwe}, {63'd0, (v.rd != 5'd0)});
      check($sformatf("v%0d_rd_addr", idx), {59'd0, radr}, {59'd0, v.rd});
    end
  endtask

  function automatic logic [XLEN-1:0] all_outs();
    return {busy, done, rd_we, illegal, csr_read, csr_write} | {58'd0, rd_addr, 1'b0}
         | result | csr_wdata | {52'd0, csr_addr};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            f3      num      src    rs1            rd     old            inv  rd wr wdata          ill lat
    vecs[0]  = '{3'b001, 12'h340, 5'd1,  64'hDEAD_BEEF, 5'd5,  64'h1234,      0,  1, 1, 64'hDEAD_BEEF, 0,  3};
    vecs[1]  = '{3'b010, 12'h300, 5'd0,  64'hFFFF,      5'd3,  64'hA00,       0,  1, 0, 64'h0,         0,  2};
    vecs[2]  = '{3'b111, 12'h340, 5'd5,  64'h0,         5'd1,  64'hFF,        0,  1, 1, 64'hFA,        0,  3};
    vecs[3]  = '{3'b011, 12'h340, 5'd2,  64'h30,        5'd0,  64'hF0,        0,  1, 1, 64'hC0,        0,  3};
    vecs[4]  = '{3'b001, 12'hF11, 5'd4,  64'h55,        5'd7,  64'h99,        0,  1, 0, 64'h0,         1,  2};
    vecs[5]  = '{3'b010, 12'h300, 5'd6,  64'h8,         5'd2,  64'h77,        1,  1, 0, 64'h0,         1,  2};
    vecs[6]  = '{3'b100, 12'h340, 5'd6,  64'h8,         5'd2,  64'h77,        0,  0, 0, 64'h0,         1,  1};
    vecs[7]  = '{3'b110, 12'h341, 5'h1F, 64'h0,         5'd9,  64'h100,       0,  1, 1, 64'h11F,       0,  3};
    vecs[8]  = '{3'b010, 12'hC00, 5'd0,  64'h3,         5'd4,  64'hABCD,      0,  1, 0, 64'h0,         0,  2};
    vecs[9]  = '{3'b101, 12'h340, 5'd0,  64'hFFFF,      5'd8,  64'h4321,      0,  1, 1, 64'h0,         0,  3};
    vecs[10] = '{3'b111, 12'hF11, 5'd0,  64'h0,         5'd31, 64'h5A5A,      0,  1, 0, 64'h0,         0,  2};

    rst = 1'b0; start = 1'b0; funct3 = '0; csr_num = '0; src_idx = '0; rs1_val = '0;
    rd_idx = '0; kill = 1'b0; csr_rdata = '0; csr_invalid = 1'b0;
    #1;
    check("reset_outputs_zero", all_outs(), 64'd0);
    #22 rst = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // kill during WRITE: strobe gated, no done, unit idle next cycle
    @(negedge phi2);
    funct3 = 3'b001; csr_num = 12'h340; src_idx = 5'd1; rs1_val = 64'h1111;
    rd_idx = 5'd5; csr_rdata = 64'h2222; csr_invalid = 1'b0; start = 1'b1;
    @(posedge phi2); #1 start = 1'b0;
    @(posedge phi2); #1;
    check("kill_pre_write_strobe", {63'd0, csr_write}, 64'd1);
    kill = 1'b1; #1;
    check("kill_write_gated", {63'd0, csr_write}, 64'd0);
    @(posedge phi2); #1 kill = 1'b0;
    check("kill_busy_after", {63'd0, busy}, 64'd0);
    check("kill_no_done", {62'd0, done, illegal}, 64'd0);
    @(negedge phi2);
    check("kill_no_done_late", {62'd0, done, illegal}, 64'd0);
    run_vec(vecs[0], 100);

    // kill beats start in IDLE
    @(negedge phi2);
    funct3 = 3'b001; start = 1'b1; kill = 1'b1;
    @(posedge phi2); #1 start = 1'b0; kill = 1'b0;
    check("kill_idle_start_ignored", {63'd0, busy}, 64'd0);

    // start while busy is ignored: second start during READ must not add a pulse
    @(negedge phi2);
    funct3 = 3'b010; csr_num = 12'h300; src_idx = 5'd0; rd_idx = 5'd3;
    csr_rdata = 64'h77; start = 1'b1;
    @(posedge phi2); #1;
    funct3 = 3'b100;
    @(posedge phi2); #1 start = 1'b0;
    check("busy_start_done", {62'd0, done, illegal}, 64'd2);
    @(posedge phi2); #1;
    check("busy_start_idle", {61'd0, busy, done, illegal}, 64'd0);

    // async reset in the middle of READ
    @(negedge phi2);
    funct3 = 3'b001; csr_num = 12'h340; src_idx = 5'd1; rs1_val = 64'h9;
    rd_idx = 5'd4; csr_rdata = 64'h3; start = 1'b1;
    @(posedge phi2); #1 start = 1'b0;
    check("rst_pre_read", {63'd0, csr_read}, 64'd1);
    #2 rst = 1'b0; #1;
    check("rst_mid_read_outputs", all_outs(), 64'd0);
    @(posedge phi2); #1;
    check("rst_held_no_write", {63'd0, csr_write}, 64'd0);
    @(negedge phi2) rst = 1'b1;
    run_vec(vecs[2], 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/csr_op_unit.md
Name: csr_op_unit

Overview:
- Sequencer for Zicsr instructions (CSRRW/RS/RC and immediate forms).
- Sits between the execute stage and the CSR file.
- Accepts one decoded CSR op, performs the CSR read, computes and conditionally issues the write, and returns the old CSR value for rd.
- Converts CSR access violations into a single illegal-instruction pulse for the trap logic.

Parameters:
- XLEN, 64, data width of CSR and register values.

Ports:
- phi2  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; accepted only in IDLE.
- funct3  in  3  instruction funct3.
- csr_num  in  12  CSR address from the instruction.
- src_idx  in  5  rs1 index (register forms) or uimm (immediate forms).
- rs1_val  in  XLEN  rs1 value (register forms).
- rd_idx  in  5  destination register index.
- kill  in  1  pipeline flush; aborts the op in flight.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; op completed successfully.
- rd_we  out  1  high with done when the latched rd_idx != 0.
- rd_addr  out  5  latched rd_idx; valid with done.
- result  out  XLEN  old CSR value; valid with done.
- illegal  out  1  one-cycle pulse; op faulted, raise illegal-instruction (cause 2).
- csr_addr  out  12  address to the CSR file.
- csr_read  out  1  read strobe to the CSR file.
- csr_write  out  1  write strobe to the CSR file.
- csr_wdata  out  XLEN  write data to the CSR file.
- csr_rdata  in  XLEN  CSR file read data (combinational).
- csr_invalid  in  1  CSR file privilege violation (combinational).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0, including result, rd_addr, csr_addr and csr_wdata.
  - Latched fields cleared.
- States: IDLE, READ, WRITE, DONE, FAULT.
- IDLE:
  - On start, latch funct3, csr_num, src_idx, rd_idx.
  - Latch the operand: rs1_val for funct3[2]=0; {59'b0, src_idx} for funct3[2]=1.
  - funct3 in {000,100} -> FAULT; otherwise -> READ.
  - start while busy is ignored.
- READ (1 cycle):
  - csr_read=1, csr_addr=latched csr_num.
  - Latch old=csr_rdata at the edge.
  - Fault if csr_invalid=1.
  - Fault if do_write=1 and csr_num[11:10]==2'b11 (read-only CSR).
  - Fault -> FAULT. Else do_write ? WRITE : DONE.
- do_write rules:
  - RW/RWI: always 1.
  - RS/RC/RSI/RCI: 1 only if latched src_idx != 0. The decision uses the index, not rs1_val.
- WRITE (1 cycle):
  - csr_write=1, csr_addr=csr_num.
  - csr_wdata: RW = operand; RS = old | operand; RC = old & ~operand.
  - Next state DONE.
  - csr_read=0.
- DONE (1 cycle):
  - done=1, result=old, rd_addr=rd_idx, rd_we=(rd_idx!=0).
  - Next state IDLE.
- FAULT (1 cycle):
  - illegal=1, done=0, rd_we=0.
  - No CSR write is ever issued for a faulting op.
  - Next state IDLE.
- Latency (start edge to done pulse):
  - Write path: 3 cycles.
  - No-write path: 2 cycles.
  - Illegal funct3: illegal pulses 1 cycle after start.
- csr_addr/csr_wdata are 0 and strobes are low outside READ/WRITE.
- kill:
  - In READ or WRITE: forces next state IDLE.
  - In WRITE, kill combinationally gates csr_write to 0, so no write is committed.
  - Suppresses the done/illegal that would have followed.
  - In DONE/FAULT: the pulse still occurs.
  - In IDLE: has priority over start, which is ignored.
- Reset mid-op: immediate return to IDLE with no strobes; the CSR file sees no partial write.

Test Plan:
- CSRRW 0x340, rs1_val=0xDEAD_BEEF, rd=5, mscratch=0x1234 -> READ then WRITE with wdata 0xDEADBEEF; done at +3 with result 0x1234, rd_we=1, rd_addr=5.
- CSRRS 0x300, src_idx=0, rd=3 -> READ only, no csr_write; done at +2 with result equal to the mstatus value.
- CSRRCI 0x340, uimm=0x5, old=0xFF -> csr_wdata 0xFA.
- CSRRC with rd=0, src_idx=2, old=0xF0, rs1_val=0x30 -> csr_wdata 0xC0, done=1, rd_we=0.
- CSRRW to 0xF11 -> illegal pulse at +2, no csr_write. Separately, csr_invalid=1 during READ -> illegal at +2, no csr_write. funct3=100 -> illegal at +1, no strobes.
- kill asserted in the WRITE cycle -> csr_write stays 0, no done, busy=0 the next cycle, and a new start is accepted.
- rst low mid-READ -> all outputs 0 immediately.
